// File: rtl/table_walk_fetch.sv
// Table walk fetch engine: reads multi-beat entries from a byte-lane DRAM,
// follows nested tables through a return stack, buffers entries in a FIFO.
module table_walk_fetch #(
    parameter int LANES       = 8,
    parameter int ENTRY_BYTES = 16,
    parameter int RAS_DEPTH   = 3,
    parameter int OB_DEPTH    = 4,
    parameter bit STEP_MODE   = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [63:0]                   new_addr,
    input  logic                          new_addr_valid,
    output logic [LANES-1:0]              dram_en,
    output logic                          dram_rdwr,
    output logic [LANES-1:0][63:0]        dram_addr,
    input  logic [LANES-1:0]              dram_valid,
    input  logic [LANES-1:0][7:0]         dram_data,
    output logic [8*ENTRY_BYTES-1:0]      entry,
    output logic                          ob_valid,
    input  logic                          ob_ready,
    output logic [$clog2(OB_DEPTH):0]     ob_count,
    output logic                          busy,
    output logic                          done,
    output logic                          ras_overflow
);

    localparam int EW    = 8 * ENTRY_BYTES;
    localparam int BEATS = ENTRY_BYTES / LANES;
    localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RPW   = $clog2(RAS_DEPTH + 1);
    localparam int OPW   = (OB_DEPTH > 1) ? $clog2(OB_DEPTH) : 1;
    localparam int CW    = $clog2(OB_DEPTH) + 1;

    localparam logic [63:0] EB64    = 64'(ENTRY_BYTES);
    localparam logic [63:0] LANES64 = 64'(LANES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_PUSH   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]       state;
    logic [63:0]      addr;
    logic [63:0]      nxt_addr;
    logic [BTW-1:0]   beat;
    logic [LANES-1:0] got;
    logic [EW-1:0]    ebuf;
    logic             walk_end;
    logic [63:0]      ras [RAS_DEPTH];
    logic [RPW-1:0]   ras_ptr;
    logic             ovf;

    logic [EW-1:0]    mem [OB_DEPTH];
    logic [OPW-1:0]   wr_ptr;
    logic [OPW-1:0]   rd_ptr;
    logic [CW-1:0]    count;

    logic [7:0]       etype;
    logic [63:0]      eptr;
    logic             is_nest;
    logic             is_end;
    logic             ras_full;
    logic             ras_empty;
    logic [RPW-1:0]   ras_top;
    logic             got_all;
    logic             last_beat;
    logic             full;
    logic             pop;
    logic             push;

    assign etype     = ebuf[EW-1 -: 8];
    assign eptr      = ebuf[63:0];
    assign is_nest   = (etype == 8'h01);
    assign is_end    = (etype == 8'hFF);
    assign ras_full  = (ras_ptr == RPW'(RAS_DEPTH));
    assign ras_empty = (ras_ptr == '0);
    assign ras_top   = ras_ptr - 1'b1;
    assign got_all   = &(got | dram_valid);
    assign last_beat = (beat == BTW'(BEATS - 1));

    assign full      = (count == CW'(OB_DEPTH));
    assign ob_valid  = (count != '0);
    assign pop       = ob_valid & ob_ready;
    assign push      = (state == S_PUSH) && (!full || pop);

    assign dram_en      = (state == S_ISSUE) ? '1 : '0;
    assign dram_rdwr    = 1'b0;
    assign entry        = mem[rd_ptr];
    assign ob_count     = count;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign ras_overflow = ovf;

    // Per-lane byte addresses for the current beat.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            dram_addr[i] = addr + 64'(beat) * LANES64 + 64'(i);
        end
    end

    // Walk state machine: issue beats, gather bytes, decode, hand to FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            addr     <= '0;
            nxt_addr <= '0;
            beat     <= '0;
            got      <= '0;
            ebuf     <= '0;
            walk_end <= 1'b0;
            ras_ptr  <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (new_addr_valid) begin
                        addr <= new_addr;
                    end else if (en) begin
                        beat  <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    got   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (dram_valid[i]) begin
                            ebuf[(int'(beat) * LANES + i) * 8 +: 8] <= dram_data[i];
                        end
                    end
                    got <= got | dram_valid;
                    if (got_all) begin
                        got <= '0;
                        if (last_beat) begin
                            beat  <= '0;
                            state <= S_DECODE;
                        end else begin
                            beat  <= beat + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DECODE: begin
                    unique case (1'b1)
                        is_nest && ras_full: begin
                            ovf   <= 1'b1;
                            state <= S_ERROR;
                        end
                        is_nest && !ras_full: begin
                            ras[ras_ptr] <= addr + EB64;
                            ras_ptr      <= ras_ptr + 1'b1;
                            nxt_addr     <= eptr;
                            walk_end     <= 1'b0;
                            state        <= S_PUSH;
                        end
                        is_end && !ras_empty: begin
                            ras_ptr  <= ras_top;
                            nxt_addr <= ras[ras_top];
                            walk_end <= 1'b0;
                            state    <= S_PUSH;
                        end
                        is_end && ras_empty: begin
                            nxt_addr <= addr + EB64;
                            walk_end <= 1'b1;
                            state    <= S_PUSH;
                        end
                        default: begin
                            nxt_addr <= addr + EB64;
                            walk_end <= 1'b0;
                            state    <= S_PUSH;
                        end
                    endcase
                end
                S_PUSH: begin
                    if (push) begin
                        addr <= nxt_addr;
                        if (walk_end) begin
                            state <= S_DONE;
                        end else if (STEP_MODE) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // FIFO storage, written on push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ebuf;
        end
    end

endmodule
